shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_seq_if.sv | 26 ++
 rtl/shift_sequencer.sv | 122 ++++++++++++
 tb/tb_shift_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/shift_seq_if.sv
// shift_seq_if
//   Request/response bundle for shift_sequencer.
//   Requester -> sequencer : start, din, shamt, op
//   Sequencer -> requester : busy, done, dout
//   Modports: master (requester side), slave (sequencer side).
interface shift_seq_if #(
    parameter int WIDTH = 32
);
    logic                       start;
    logic [WIDTH-1:0]           din;
    logic [$clog2(WIDTH)-1:0]   shamt;
    logic [1:0]                 op;
    logic                       busy;
    logic                       done;
    logic [WIDTH-1:0]           dout;

    modport master (
        output start, din, shamt, op,
        input  busy, done, dout
    );

    modport slave (
        input  start, din, shamt, op,
        output busy, done, dout
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer
//   Multi-cycle shifter: a captured operand is shifted by at most 3 bit
//   positions per cycle until the requested distance is reached, so a
//   32-bit shift by 31 takes 11 SHIFT cycles plus one DONE cycle.
//
//   Ports:
//     clk    - single clock, rising edge
//     reset  - synchronous, active-high
//     bus    - shift_seq_if.slave
//                start/din/shamt/op : request, sampled in IDLE or DONE only
//                busy               : high while in SHIFT
//                done               : one-cycle pulse in DONE
//                dout               : current accumulator (result on done)
//
//   op encoding: 00 LSL, 01 LSR, 10 ASR, 11 ROR (rotate only when the
//   SHIFT_SEQ_ROTATE_EN macro is defined; otherwise 11 acts as LSR and no
//   rotate path is built).
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    shift_seq_if.slave   bus
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_LSL = 2'b00;
    localparam logic [1:0] OP_ASR = 2'b10;
`ifdef SHIFT_SEQ_ROTATE_EN
    localparam logic [1:0] OP_ROR = 2'b11;
`endif

    logic [1:0]        state_q, state_d;
    logic [WIDTH-1:0]  acc_q,   acc_d;
    logic [SW-1:0]     rem_q,   rem_d;
    logic [1:0]        op_q,    op_d;

    logic              accept;
    logic [1:0]        step;
    logic [SW-1:0]     rem_next;
    logic [WIDTH-1:0]  acc_shifted;

    // Single 0..3-distance shift stage. Right shifts are done on the
    // operand extended by 3 fill bits on top: zeros (LSR), sign copies
    // (ASR) or the low 3 bits of the operand itself (ROR), which is all a
    // shift of at most 3 ever pulls in.
    function automatic logic [WIDTH-1:0] shift_stage(
        input logic [WIDTH-1:0] a,
        input logic [1:0]       o,
        input logic [1:0]       s
    );
        logic [2:0]       hi;
        logic [WIDTH+2:0] ext;
        logic [WIDTH+2:0] shr;
        logic [WIDTH-1:0] res;
        case (o)
            OP_ASR:  hi = {3{a[WIDTH-1]}};
`ifdef SHIFT_SEQ_ROTATE_EN
            OP_ROR:  hi = a[2:0];
`endif
            default: hi = 3'b000;
        endcase
        ext = {hi, a};
        shr = ext >> s;
        if (o == OP_LSL) res = a << s;
        else             res = shr[WIDTH-1:0];
        return res;
    endfunction

    // Start is only honoured outside SHIFT; in SHIFT it is simply dropped.
    assign accept      = bus.start && (state_q != ST_SHIFT);
    assign step        = (rem_q > SW'(3)) ? 2'd3 : rem_q[1:0];
    assign rem_next    = rem_q - SW'(step);
    assign acc_shifted = shift_stage(acc_q, op_q, step);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    acc_d   = bus.din;
                    rem_d   = bus.shamt;
                    op_d    = bus.op;
                    state_d = (bus.shamt != '0) ? ST_SHIFT : ST_DONE;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                acc_d = acc_shifted;
                rem_d = rem_next;
                if (rem_next == '0) state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    assign bus.busy = (state_q == ST_SHIFT);
    assign bus.done = (state_q == ST_DONE);
    assign bus.dout = acc_q;
endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] last_res = 32'h0;

    always #5 clk = ~clk;

    shift_seq_if #(.WIDTH(32)) bus ();

    shift_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: whole-distance shift in one go, plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [31:0] d, input int s, input logic [1:0] o);
        logic [31:0] r;
        case (o)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = d[31] ? ~((~d) >> s) : (d >> s);
            default: begin
`ifdef SHIFT_SEQ_ROTATE_EN
                r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
`else
                r = d >> s;
`endif
            end
        endcase
        return r;
    endfunction

    function automatic int ref_latency(input int s);
        return 1 + (s + 2) / 3;
    endfunction

    // Called at a negedge in IDLE or DONE. Returns at the negedge of the
    // done cycle with start low, so a follow-up call is back-to-back.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o,
                          input string tag);
        int lat = ref_latency(int'(s));
        logic [31:0] exp = ref_result(d, int'(s), o);
        bus.start = 1'b1; bus.din = d; bus.shamt = s; bus.op = o;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.din = $urandom; bus.shamt = 5'($urandom); bus.op = 2'($urandom);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            chk({tag, ".busy"}, 32'(bus.busy), 32'(k < lat));
            chk({tag, ".done"}, 32'(bus.done), 32'(k == lat));
            if (k < lat) begin
                // Junk request while busy must be ignored
                bus.start = 1'($urandom);
                bus.din   = 32'hFFFF_FFFF ^ 32'($urandom_range(0, 15));
                bus.shamt = 5'($urandom);
                bus.op    = 2'($urandom);
            end else begin
                chk({tag, ".dout"}, bus.dout, exp);
                bus.start = 1'b0;
            end
        end
        last_res = exp;
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        chk({tag, ".idle_busy"}, 32'(bus.busy), 32'h0);
        chk({tag, ".idle_done"}, 32'(bus.done), 32'h0);
        chk({tag, ".idle_dout"}, bus.dout, last_res);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.din = '0; bus.shamt = '0; bus.op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.busy", 32'(bus.busy), 32'h0);
        chk("rst.done", 32'(bus.done), 32'h0);
        chk("rst.dout", bus.dout, 32'h0);
        reset = 1'b0;
        idle_cycle("post_rst");

        // Directed cases
        run_op(32'h0000_000F, 5'd2, 2'b00, "lsl2");
        idle_cycle("lsl2");
        run_op(32'h8000_0000, 5'd31, 2'b10, "asr31");
        idle_cycle("asr31");
        run_op(32'h8000_0000, 5'd31, 2'b01, "lsr31");
        idle_cycle("lsr31");
        for (int o = 0; o < 4; o++) begin
            run_op(32'hDEAD_BEEF, 5'd0, 2'(o), "sh0");
            idle_cycle("sh0");
        end
        run_op(32'h0000_0001, 5'd7, 2'b00, "b2b_a");
        run_op(32'h0000_0080, 5'd3, 2'b01, "b2b_b");
        idle_cycle("b2b");
        run_op(32'h0000_0001, 5'd1, 2'b11, "op11");
        idle_cycle("op11");
        run_op(32'h1234_5678, 5'd5, 2'b11, "op11b");
        idle_cycle("op11b");

        // Reset in the middle of a shamt=20 operation
        bus.start = 1'b1; bus.din = 32'hA5A5_A5A5; bus.shamt = 5'd20; bus.op = 2'b01;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst.busy_before", 32'(bus.busy), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst.busy", 32'(bus.busy), 32'h0);
        chk("midrst.dout", bus.dout, 32'h0);
        last_res = 32'h0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("midrst.no_done", 32'(bus.done), 32'h0);
            chk("midrst.no_busy", 32'(bus.busy), 32'h0);
        end

        // Reset beats a simultaneous start
        run_op(32'h0F0F_0F0F, 5'd4, 2'b00, "pre_rs");
        reset = 1'b1; bus.start = 1'b1; bus.din = 32'h1111_1111; bus.shamt = 5'd0;
        @(negedge clk);
        reset = 1'b0; bus.start = 1'b0;
        last_res = 32'h0;
        chk("rst_start.done", 32'(bus.done), 32'h0);
        chk("rst_start.dout", bus.dout, 32'h0);
        idle_cycle("rst_start");

        // Random operations, random gaps (0 gap = back-to-back)
        for (int i = 0; i < 150; i++) begin
            int gap = $urandom_range(0, 2);
            logic [4:0] s = (i % 10 == 0) ? 5'd31 : 5'($urandom);
            for (int g = 0; g < gap; g++) idle_cycle("rnd");
            run_op($urandom, s, 2'($urandom), "rnd");
        end
        idle_cycle("end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
